// File: rtl/iiitb_muldiv_if.sv
// Handshake and operand bus between the execute stage and the iterative
// multiply/divide unit.
interface iiitb_muldiv_if #(
    parameter int XLEN = 32
);
    logic            start;
    logic [2:0]      op;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic            abort;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;

    modport master (
        output start, op, a, b, abort,
        input  busy, done, result
    );

    modport slave (
        input  start, op, a, b, abort,
        output busy, done, result
    );
endinterface

// File: rtl/iiitb_muldiv.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply and
// restoring divide, one bit per cycle, with start/busy/done handshake.
module iiitb_muldiv #(
    parameter int XLEN = 32
) (
    input  logic           clk,
    input  logic           RN,
    iiitb_muldiv_if.slave  bus
);
    localparam int CW = $clog2(XLEN + 1);
    localparam logic [XLEN-1:0]   ONE_X  = {{(XLEN-1){1'b0}}, 1'b1};
    localparam logic [2*XLEN-1:0] ONE_2X = {{(2*XLEN-1){1'b0}}, 1'b1};
    localparam logic [XLEN-1:0]   MIN_X  = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0]   ONES_X = {XLEN{1'b1}};
    localparam logic [XLEN-1:0]   ZERO_X = {XLEN{1'b0}};
    localparam logic [CW-1:0]     LAST_CNT = CW'(XLEN - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    function automatic logic [XLEN-1:0] neg_if(input logic [XLEN-1:0] x, input logic neg);
        neg_if = neg ? (~x + ONE_X) : x;
    endfunction

    function automatic logic [2*XLEN-1:0] neg_if2(input logic [2*XLEN-1:0] x, input logic neg);
        neg_if2 = neg ? (~x + ONE_2X) : x;
    endfunction

    state_t            state_r, state_s;
    logic              busy_r, done_r;
    logic [XLEN-1:0]   result_r;
    logic              busy_s, done_s;
    logic [XLEN-1:0]   result_s;

    logic [2:0]        op_r;
    logic              neg_a_r, neg_b_r;
    logic [XLEN-1:0]   opnd_r;      // |multiplicand| or |divisor|
    logic [2*XLEN-1:0] acc_r;       // product, or remainder:quotient
    logic [CW-1:0]     cnt_r;

    // Request decode on the incoming operands
    logic              accept_s, signed_a_s, signed_b_s, neg_a_s, neg_b_s;
    logic              is_rem_s, b_zero_s, ovf_s, short_s;
    logic [XLEN-1:0]   short_val_s;

    assign accept_s   = ((state_r == ST_IDLE) || (state_r == ST_DONE)) && bus.start && !bus.abort;
    assign signed_a_s = (bus.op == 3'b001) || (bus.op == 3'b010) || (bus.op == 3'b100) || (bus.op == 3'b110);
    assign signed_b_s = (bus.op == 3'b001) || (bus.op == 3'b100) || (bus.op == 3'b110);
    assign neg_a_s    = signed_a_s && bus.a[XLEN-1];
    assign neg_b_s    = signed_b_s && bus.b[XLEN-1];
    assign is_rem_s   = bus.op[1];
    assign b_zero_s   = (bus.b == ZERO_X);
    assign ovf_s      = ((bus.op == 3'b100) || (bus.op == 3'b110)) && (bus.a == MIN_X) && (bus.b == ONES_X);
    assign short_s    = bus.op[2] && (b_zero_s || ovf_s);

    // Result for divide-by-zero and signed-overflow cases
    always_comb begin
        short_val_s = ZERO_X;
        if (b_zero_s) begin
            short_val_s = is_rem_s ? bus.a : ONES_X;
        end else if (ovf_s) begin
            short_val_s = is_rem_s ? ZERO_X : MIN_X;
        end else begin
            short_val_s = ZERO_X;
        end
    end

    // One iteration of the multiply and divide datapaths
    logic [XLEN:0]     mul_sum_s, div_shift_s, div_diff_s;
    logic [2*XLEN-1:0] mul_step_s, div_step_s;

    assign mul_sum_s   = {1'b0, acc_r[2*XLEN-1:XLEN]} + {1'b0, opnd_r};
    assign mul_step_s  = acc_r[0] ? {mul_sum_s, acc_r[XLEN-1:1]} : {1'b0, acc_r[2*XLEN-1:1]};
    assign div_shift_s = {acc_r[2*XLEN-1:XLEN], acc_r[XLEN-1]};
    assign div_diff_s  = div_shift_s - {1'b0, opnd_r};
    assign div_step_s  = div_diff_s[XLEN] ? {div_shift_s[XLEN-1:0], acc_r[XLEN-2:0], 1'b0}
                                          : {div_diff_s[XLEN-1:0],  acc_r[XLEN-2:0], 1'b1};

    // Sign correction and output selection applied in FIX
    logic [2*XLEN-1:0] prod_s;
    logic [XLEN-1:0]   quot_s, rem_s, fix_val_s;

    assign prod_s = neg_if2(acc_r, neg_a_r ^ neg_b_r);
    assign quot_s = neg_if(acc_r[XLEN-1:0], neg_a_r ^ neg_b_r);
    assign rem_s  = neg_if(acc_r[2*XLEN-1:XLEN], neg_a_r);

    // Pick the architectural result for the completed operation
    always_comb begin
        fix_val_s = ZERO_X;
        case (op_r)
            3'b000:                 fix_val_s = prod_s[XLEN-1:0];
            3'b001, 3'b010, 3'b011: fix_val_s = prod_s[2*XLEN-1:XLEN];
            3'b100, 3'b101:         fix_val_s = quot_s;
            3'b110, 3'b111:         fix_val_s = rem_s;
            default:                fix_val_s = ZERO_X;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or negedge RN) begin
        if (!RN) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // FSM next-state logic; abort wins over start
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (accept_s) begin
                    state_s = short_s ? ST_DONE : ST_BUSY;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (bus.abort) begin
                    state_s = ST_IDLE;
                end else if (cnt_r == LAST_CNT) begin
                    state_s = ST_FIX;
                end else begin
                    state_s = ST_BUSY;
                end
            end
            ST_FIX: begin
                if (bus.abort) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_DONE;
                end
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // FSM output logic: next values for the registered outputs
    always_comb begin
        busy_s   = (state_s == ST_BUSY) || (state_s == ST_FIX);
        done_s   = (state_s == ST_DONE);
        result_s = result_r;
        if (accept_s && short_s) begin
            result_s = short_val_s;
        end else if ((state_r == ST_FIX) && !bus.abort) begin
            result_s = fix_val_s;
        end else begin
            result_s = result_r;
        end
    end

    // Registered handshake outputs and result
    always_ff @(posedge clk or negedge RN) begin
        if (!RN) begin
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            result_r <= ZERO_X;
        end else begin
            busy_r   <= busy_s;
            done_r   <= done_s;
            result_r <= result_s;
        end
    end

    // Operand capture and per-cycle iteration
    always_ff @(posedge clk or negedge RN) begin
        if (!RN) begin
            op_r    <= 3'b000;
            neg_a_r <= 1'b0;
            neg_b_r <= 1'b0;
            opnd_r  <= ZERO_X;
            acc_r   <= {(2*XLEN){1'b0}};
            cnt_r   <= {CW{1'b0}};
        end else if (accept_s) begin
            op_r    <= bus.op;
            neg_a_r <= neg_a_s;
            neg_b_r <= neg_b_s;
            opnd_r  <= neg_if(bus.b, neg_b_s);
            acc_r   <= {ZERO_X, neg_if(bus.a, neg_a_s)};
            cnt_r   <= {CW{1'b0}};
        end else if ((state_r == ST_BUSY) && !bus.abort) begin
            acc_r   <= op_r[2] ? div_step_s : mul_step_s;
            cnt_r   <= cnt_r + CW'(1);
        end else begin
            cnt_r   <= cnt_r;
        end
    end

    assign bus.busy   = busy_r;
    assign bus.done   = done_r;
    assign bus.result = result_r;
endmodule
